// File: rtl/top_transceiver.sv
// top_transceiver: UART-style transmitter that sends the ASCII hex digit of a 4-bit address
// as a 10-bit frame (start, 8 data LSB first, stop) on an idle-high line.
module top_transceiver #(
  parameter int CLKS_PER_BIT = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] input_addr,
  input  logic       start,
  output logic       out
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    rom;
  logic          tick;
  // ASCII hex digit: '0'..'9' then 'A'..'F'
  assign rom  = {4'h0, input_addr} + ((input_addr < 4'd10) ? 8'h30 : 8'h37);
  assign tick = (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      out   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          shift <= rom;
          cnt   <= '0;
          idx   <= '0;
          out   <= 1'b0;
          state <= START;
        end
        START: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            out   <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick && idx == 3'd7) begin
            out   <= 1'b1;
            state <= STOP;
          end else if (tick) begin
            idx   <= idx + 1'b1;
            shift <= {1'b0, shift[7:1]};
            out   <= shift[1];
          end
        end
        STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          out   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_top_transceiver.sv
// tb_top_transceiver: table-driven frame checks with a per-cycle expected-line scoreboard,
// plus reset, held-start and asynchronous-abort sequences.
module tb_top_transceiver;
  localparam int C = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] input_addr = 4'd5;
  logic       start = 1'b1;
  logic       out;
  logic       q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] ch;
    int         poke;
  } vec_t;
  vec_t tbl[6];

  top_transceiver #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .input_addr(input_addr),
    .start(start),
    .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] ch);
    logic [9:0] f;
    f = {1'b1, ch, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < C; c++) q.push_back(f[b]);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(1'b1);
  endtask

  // Each cycle: drive start at negedge, then compare out against the next expected value.
  task automatic run(input string name, input int n, input int poke, input int hold);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = (i < hold) || (i == poke);
      if (i == poke) input_addr = 4'd3;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: scoreboard empty at cycle %0d", name, i);
      end else chk(name, out, q.pop_front());
    end
  endtask

  initial begin
    tbl[0] = '{4'd5,  8'h35, -1};
    tbl[1] = '{4'd0,  8'h30, -1};
    tbl[2] = '{4'd15, 8'h46, -1};
    tbl[3] = '{4'd9,  8'h39, -1};
    tbl[4] = '{4'd12, 8'h43, -1};
    tbl[5] = '{4'd5,  8'h35, 15};
    // Reset held with start asserted: line must stay idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_idle", out, 1'b1);
    end
    push_frame(8'h35);
    push_idle(2 * C);
    @(negedge clk);
    rst_n = 1'b1;
    run("reset_release_frame", 10 * C + 2 * C, -1, 0);
    // Table of single frames; last entry pokes start with addr=3 mid-frame
    foreach (tbl[j]) begin
      push_frame(tbl[j].ch);
      push_idle(3 * C);
      @(negedge clk);
      start = 1'b1;
      input_addr = tbl[j].addr;
      run($sformatf("frame_addr%0d", tbl[j].addr), 13 * C, tbl[j].poke, 0);
    end
    // Held start: back-to-back 0x41 frames with one idle cycle between
    for (int j = 0; j < 3; j++) begin
      push_frame(8'h41);
      push_idle(1);
    end
    push_idle(2 * C);
    @(negedge clk);
    start = 1'b1;
    input_addr = 4'd10;
    run("held_start", 3 * (10 * C + 1) + 2 * C, -1, 3 * (10 * C + 1) - 1);
    // Async abort during data bit 4 (frame cycles 5*C..6*C-1)
    push_frame(8'h37);
    @(negedge clk);
    start = 1'b1;
    input_addr = 4'd7;
    run("abort_pre", 5 * C + 2, -1, 0);
    #2 rst_n = 1'b0;
    #1 chk("abort_async", out, 1'b1);
    q.delete();
    push_idle(3 * C);
    @(negedge clk);
    rst_n = 1'b1;
    run("abort_idle", 3 * C, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
